ps2_frame_decoder: RTL and testbench

Front end of the keyboard path: it receives raw PS/2 clock and data from the keyboard and produces the steady `key_code` byte consumed by `keyboard_buffer`. It synchronizes and glitch-filters the PS/2 lines and deserializes 11-bit device-to-host frames. It folds the E0/F0 prefix bytes into flags and maintains a held code for the currently pressed key. A per-event strobe interface is exposed alongside for future consumers.

---
 rtl/ps2_frame_decoder.sv | 186 ++++++++++++++++++
 tb/tb_ps2_frame_decoder.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/ps2_frame_decoder.sv
// PS/2 device-to-host frame decoder: synchronizes and filters ps2c/ps2d, deserializes 11-bit frames,
// folds E0/F0 prefixes into flags and holds the pressed key code. Define PS2_PARITY_CHECK_EN to reject odd-parity failures.
module ps2_frame_decoder #(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       clk_50mhz,
  input  logic       reset,
  input  logic       ps2c,
  input  logic       ps2d,
  output logic [7:0] key_code,
  output logic [7:0] scan_code,
  output logic       scan_valid,
  output logic       scan_break,
  output logic       scan_ext,
  output logic       frame_err
);

`ifdef PS2_PARITY_CHECK_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif

  localparam int            WD_W      = $clog2(TIMEOUT_CYC + 1);
  localparam logic [7:0]    FILT_LAST = 8'(FILTER_LEN - 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_PARITY, ST_STOP} state_t;

  logic            ps2c_s1_q, ps2c_s2_q, ps2d_s1_q, ps2d_s2_q;
  logic            fc_q, fc_d;
  logic [7:0]      filt_cnt_q, filt_cnt_d;
  logic            fall_q, fall_d;
  state_t          state_q, state_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic            par_q, par_d;
  logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
  logic            ext_pend_q, ext_pend_d, brk_pend_q, brk_pend_d;
  logic [7:0]      key_code_q, key_code_d, scan_code_q, scan_code_d;
  logic            scan_valid_q, scan_valid_d, scan_break_q, scan_break_d;
  logic            scan_ext_q, scan_ext_d, frame_err_q, frame_err_d;
  logic            deliver;

  always_comb begin
    fc_d         = fc_q;
    filt_cnt_d   = '0;
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    par_d        = par_q;
    wd_cnt_d     = wd_cnt_q;
    ext_pend_d   = ext_pend_q;
    brk_pend_d   = brk_pend_q;
    key_code_d   = key_code_q;
    scan_code_d  = scan_code_q;
    scan_break_d = scan_break_q;
    scan_ext_d   = scan_ext_q;
    scan_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    deliver      = 1'b0;

    // Filtered clock only follows after FILTER_LEN consecutive disagreeing cycles.
    if (ps2c_s2_q != fc_q) begin
      if (filt_cnt_q == FILT_LAST) begin
        fc_d = ps2c_s2_q;
      end else begin
        filt_cnt_d = filt_cnt_q + 8'd1;
      end
    end
    fall_d = fc_q & ~fc_d;

    if (state_q == ST_IDLE) begin
      wd_cnt_d = '0;
      if (fall_q) begin
        if (!ps2d_s2_q) begin
          state_d   = ST_DATA;
          bit_cnt_d = '0;
        end else begin
          frame_err_d = 1'b1;
        end
      end
    end else if (fall_q) begin
      wd_cnt_d = '0;
      case (state_q)
        ST_DATA: begin
          shift_d   = {ps2d_s2_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = ST_PARITY;
        end
        ST_PARITY: begin
          par_d   = ps2d_s2_q;
          state_d = ST_STOP;
        end
        default: begin
          state_d = ST_IDLE;
          if (ps2d_s2_q && (!PARITY_EN || (^{shift_q, par_q}))) deliver = 1'b1;
          else frame_err_d = 1'b1;
        end
      endcase
    end else if (wd_cnt_q == WD_LAST) begin
      state_d     = ST_IDLE;
      wd_cnt_d    = '0;
      frame_err_d = 1'b1;
    end else begin
      wd_cnt_d = wd_cnt_q + 1'b1;
    end

    if (deliver) begin
      if (shift_q == 8'hE0) begin
        ext_pend_d = 1'b1;
      end else if (shift_q == 8'hF0) begin
        brk_pend_d = 1'b1;
      end else begin
        scan_code_d  = shift_q;
        scan_break_d = brk_pend_q;
        scan_ext_d   = ext_pend_q;
        scan_valid_d = 1'b1;
        ext_pend_d   = 1'b0;
        brk_pend_d   = 1'b0;
        if (!brk_pend_q) key_code_d = shift_q;
        else if (key_code_q == shift_q) key_code_d = 8'h00;
      end
    end

    if (frame_err_d) begin
      ext_pend_d = 1'b0;
      brk_pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk_50mhz or posedge reset) begin
    if (reset) begin
      ps2c_s1_q    <= 1'b1;
      ps2c_s2_q    <= 1'b1;
      ps2d_s1_q    <= 1'b1;
      ps2d_s2_q    <= 1'b1;
      fc_q         <= 1'b1;
      filt_cnt_q   <= '0;
      fall_q       <= 1'b0;
      state_q      <= ST_IDLE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      par_q        <= 1'b0;
      wd_cnt_q     <= '0;
      ext_pend_q   <= 1'b0;
      brk_pend_q   <= 1'b0;
      key_code_q   <= '0;
      scan_code_q  <= '0;
      scan_valid_q <= 1'b0;
      scan_break_q <= 1'b0;
      scan_ext_q   <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      ps2c_s1_q    <= ps2c;
      ps2c_s2_q    <= ps2c_s1_q;
      ps2d_s1_q    <= ps2d;
      ps2d_s2_q    <= ps2d_s1_q;
      fc_q         <= fc_d;
      filt_cnt_q   <= filt_cnt_d;
      fall_q       <= fall_d;
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      par_q        <= par_d;
      wd_cnt_q     <= wd_cnt_d;
      ext_pend_q   <= ext_pend_d;
      brk_pend_q   <= brk_pend_d;
      key_code_q   <= key_code_d;
      scan_code_q  <= scan_code_d;
      scan_valid_q <= scan_valid_d;
      scan_break_q <= scan_break_d;
      scan_ext_q   <= scan_ext_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign key_code   = key_code_q;
  assign scan_code  = scan_code_q;
  assign scan_valid = scan_valid_q;
  assign scan_break = scan_break_q;
  assign scan_ext   = scan_ext_q;
  assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_ps2_frame_decoder.sv
// Randomized bench for ps2_frame_decoder against an event-level model of the PS/2 byte stream.
module tb_ps2_frame_decoder;

`ifdef PS2_PARITY_CHECK_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  localparam int PH = 24;   // PS/2 half-period in system clocks
  localparam int GO = 14;   // glitch offset within a half-period

  logic       clk = 1'b0;
  logic       rst, ps2c, ps2d;
  logic [7:0] key_code, scan_code;
  logic       scan_valid, scan_break, scan_ext, frame_err;

  ps2_frame_decoder #(.FILTER_LEN(8), .TIMEOUT_CYC(50000)) dut (
    .clk_50mhz(clk), .reset(rst), .ps2c(ps2c), .ps2d(ps2d),
    .key_code(key_code), .scan_code(scan_code), .scan_valid(scan_valid),
    .scan_break(scan_break), .scan_ext(scan_ext), .frame_err(frame_err)
  );

  always #10 clk = ~clk;

  int checks = 0, errors = 0;
  int n_valid = 0, n_err = 0;
  int exp_valid = 0, exp_err = 0;
  bit m_ext = 0, m_brk = 0, m_cbrk = 0, m_cext = 0;
  logic [7:0] m_key = 8'h00, m_code = 8'h00;

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (scan_valid) n_valid++;
    if (frame_err) n_err++;
    if (scan_valid || frame_err) check_eq("strobe_excl", int'(scan_valid & frame_err), 0);
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic half(input logic lvl, input bit glitch);
    ps2c = lvl;
    if (glitch) begin
      wait_cyc(GO); ps2c = ~lvl; wait_cyc(3); ps2c = lvl; wait_cyc(PH - GO - 3);
    end else begin
      wait_cyc(PH);
    end
  endtask

  task automatic send_bit(input logic d, input bit glitch);
    ps2d = d;
    half(1'b1, glitch);
    half(1'b0, glitch);
    ps2c = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit flip, input bit glitch);
    logic [10:0] fr;
    fr = {1'b1, ~(^b) ^ flip, b, 1'b0};
    for (int i = 0; i < 11; i++) send_bit(fr[i], glitch);
    half(1'b1, 1'b0);
  endtask

  // Expected effect of one complete frame, derived from the byte-stream rules.
  task automatic model_frame(input logic [7:0] b, input bit flip);
    if (flip && PAR_EN) begin
      exp_err++; m_ext = 0; m_brk = 0;
    end else if (b == 8'hE0) begin
      m_ext = 1;
    end else if (b == 8'hF0) begin
      m_brk = 1;
    end else begin
      exp_valid++;
      m_code = b; m_cbrk = m_brk; m_cext = m_ext;
      if (!m_brk) m_key = b;
      else if (m_key == b) m_key = 8'h00;
      m_ext = 0; m_brk = 0;
    end
  endtask

  task automatic check_state(input string tag);
    check_eq({tag, "_nvalid"}, n_valid, exp_valid);
    check_eq({tag, "_nerr"}, n_err, exp_err);
    check_eq({tag, "_code"}, int'(scan_code), int'(m_code));
    check_eq({tag, "_brk"}, int'(scan_break), int'(m_cbrk));
    check_eq({tag, "_ext"}, int'(scan_ext), int'(m_cext));
    check_eq({tag, "_key"}, int'(key_code), int'(m_key));
  endtask

  task automatic do_frame(input string tag, input logic [7:0] b, input bit flip, input bit glitch);
    send_frame(b, flip, glitch);
    model_frame(b, flip);
    check_state(tag);
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, "_key"}, int'(key_code), 0);
    check_eq({tag, "_code"}, int'(scan_code), 0);
    check_eq({tag, "_valid"}, int'(scan_valid), 0);
    check_eq({tag, "_brk"}, int'(scan_break), 0);
    check_eq({tag, "_ext"}, int'(scan_ext), 0);
    check_eq({tag, "_err"}, int'(frame_err), 0);
  endtask

  initial begin
    logic [7:0] b;
    rst = 1'b1; ps2c = 1'b1; ps2d = 1'b1;
    wait_cyc(5);
    check_zero("reset");
    rst = 1'b0;
    wait_cyc(10);

    do_frame("make_1c", 8'h1C, 0, 0);
    do_frame("pre_f0", 8'hF0, 0, 0);
    do_frame("brk_1c", 8'h1C, 0, 0);
    do_frame("make_1c_b", 8'h1C, 0, 1);
    do_frame("pre_e0", 8'hE0, 0, 0);
    do_frame("pre_f0_b", 8'hF0, 0, 0);
    do_frame("ebrk_75", 8'h75, 0, 0);
    do_frame("badpar_1c", 8'h1C, 1, 0);

    // Lone falling edge with data high is a bad start bit.
    do_frame("pre_f0_c", 8'hF0, 0, 0);
    send_bit(1'b1, 0);
    half(1'b1, 1'b0);
    exp_err++; m_ext = 0; m_brk = 0;
    check_state("badstart");

    // Pending break, then a frame stalling after 5 data bits: the timeout drops the prefix.
    do_frame("pre_f0_d", 8'hF0, 0, 0);
    send_bit(1'b0, 0);
    for (int i = 0; i < 5; i++) send_bit(1'($urandom_range(0, 1)), 0);
    wait_cyc(50100);
    exp_err++; m_ext = 0; m_brk = 0;
    check_state("timeout");
    do_frame("after_to_32", 8'h32, 0, 0);

    // Reset in the middle of a glitchy frame.
    send_bit(1'b0, 1);
    for (int i = 0; i < 3; i++) send_bit(1'b1, 1);
    #3 rst = 1'b1;
    #1 check_zero("midrst");
    m_key = 8'h00; m_code = 8'h00; m_cbrk = 0; m_cext = 0; m_ext = 0; m_brk = 0;
    wait_cyc(5);
    rst = 1'b0;
    wait_cyc(20);
    do_frame("after_rst_4d", 8'h4D, 0, 1);

    for (int n = 0; n < 30; n++) begin
      case ($urandom_range(0, 4))
        0:       b = 8'hE0;
        1:       b = 8'hF0;
        2:       b = m_key;
        default: b = 8'($urandom);
      endcase
      do_frame("rand", b, $urandom_range(0, 7) == 0, 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
